// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle MIPS control path.
// Used by the sequencer, its wait timers, the decoder and the ALU.
package cpu_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StFault  = 3'd6
    } seq_state_t;

    localparam logic [1:0] PC_SRC_PC4    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [3:0] ALU_CTRL_INVALID = 4'hF;

    // Where the sequencer goes after an instruction retires.
    function automatic seq_state_t retire_next(input logic run);
        return run ? StFetch : StIdle;
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control/handshake bundle between the sequencer and the datapath/memories.
// master = sequencer side, slave = datapath and memory side.
interface cpu_sequencer_if;

    logic       run;
    logic       write_reg;
    logic       write_mem;
    logic       read_ram;
    logic       jal;
    logic       branch;
    logic [3:0] alu_ctrl;
    logic       alu_zero;
    logic       imem_req;
    logic       imem_ack;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ack;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic       retired;
    logic       fault;
    logic [2:0] state;

    modport master (
        input  run, write_reg, write_mem, read_ram, jal, branch, alu_ctrl, alu_zero,
        input  imem_ack, dmem_ack,
        output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, reg_we, retired,
        output fault, state
    );

    modport slave (
        output run, write_reg, write_mem, read_ram, jal, branch, alu_ctrl, alu_zero,
        output imem_ack, dmem_ack,
        input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, reg_we, retired,
        input  fault, state
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts unacknowledged request cycles on one memory port and flags expiry
// in the cycle where the MEM_TIMEOUT-th request cycle also goes unanswered.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic active_i,
    input  logic ack_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            waiting;

    assign waiting   = active_i && !ack_i;
    // An ack in the expiry cycle wins, so expiry needs the ack to be absent.
    assign expired_o = waiting && (cnt_q == CntW'(MEM_TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (waiting && !expired_o) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the MIPS core.
// Strobes are Mealy outputs of the registered state; state and fault are registered.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input logic            clk,
    input logic            rst,
    cpu_sequencer_if.master bus
);

    seq_state_t state_q;
    seq_state_t state_d;
    logic       fault_q;

    logic       imem_req;
    logic       ir_we;
    logic       dmem_req;
    logic       dmem_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic       retired;

    logic       imem_expired;
    logic       dmem_expired;
    logic       imem_clear;
    logic       dmem_clear;

    // Counters restart on each entry so a stale count never carries over.
    assign imem_clear = (state_d == StFetch) && (state_q != StFetch);
    assign dmem_clear = (state_d == StMem) && (state_q != StMem);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_imem_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (imem_clear),
        .active_i (state_q == StFetch),
        .ack_i    (bus.imem_ack),
        .expired_o(imem_expired)
    );

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_dmem_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (dmem_clear),
        .active_i (state_q == StMem),
        .ack_i    (bus.dmem_ack),
        .expired_o(dmem_expired)
    );

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        pc_we    = 1'b0;
        pc_src   = PC_SRC_PC4;
        reg_we   = 1'b0;
        retired  = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.run) state_d = StFetch;
            end
            StFetch: begin
                imem_req = 1'b1;
                if (bus.imem_ack) begin
                    ir_we   = 1'b1;
                    state_d = StDecode;
                end else if (imem_expired) begin
                    state_d = StFault;
                end
            end
            StDecode: begin
                state_d = (bus.alu_ctrl == ALU_CTRL_INVALID) ? StFault : StExec;
            end
            StExec: begin
                if (bus.branch) begin
                    // bne: taken when the operands differ
                    pc_we   = 1'b1;
                    pc_src  = bus.alu_zero ? PC_SRC_PC4 : PC_SRC_BRANCH;
                    retired = 1'b1;
                    state_d = retire_next(bus.run);
                end else if (bus.write_mem || bus.read_ram) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                dmem_req = 1'b1;
                dmem_we  = bus.write_mem;
                if (bus.dmem_ack) begin
                    if (bus.read_ram) begin
                        state_d = StWb;
                    end else begin
                        pc_we   = 1'b1;
                        retired = 1'b1;
                        state_d = retire_next(bus.run);
                    end
                end else if (dmem_expired) begin
                    state_d = StFault;
                end
            end
            StWb: begin
                reg_we  = bus.write_reg;
                pc_we   = 1'b1;
                pc_src  = bus.jal ? PC_SRC_JUMP : PC_SRC_PC4;
                retired = 1'b1;
                state_d = retire_next(bus.run);
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= (state_d == StFault);
        end
    end

    assign bus.imem_req = imem_req;
    assign bus.ir_we    = ir_we;
    assign bus.dmem_req = dmem_req;
    assign bus.dmem_we  = dmem_we;
    assign bus.pc_we    = pc_we;
    assign bus.pc_src   = pc_src;
    assign bus.reg_we   = reg_we;
    assign bus.retired  = retired;
    assign bus.fault    = fault_q;
    assign bus.state    = state_q;

endmodule
